ncl_sync_bridge: RTL

//  Clocked front/back end for a WIDTH-bit dual-rail NCL ripple-carry adder chain (fulladd cells).

---
 rtl/ncl_pkg.sv | 31 +++
 rtl/ncl_sync_vec.sv | 27 ++
 rtl/ncl_sync_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// Shared dual-rail NCL types, constants and helpers for the sync bridge.
// Rail encoding: rail[1]=TRUE, rail[0]=FALSE, 00=NULL, 11=illegal.
package ncl_pkg;

    typedef logic [1:0] dr_t;

    localparam dr_t DR_NULL = 2'b00;
    localparam dr_t DR_T    = 2'b10;
    localparam dr_t DR_F    = 2'b01;

    typedef enum logic {I_NULL, I_DATA} inj_state_t;
    typedef enum logic {C_DATA, C_NULL} col_state_t;

    function automatic dr_t dr_encode(input logic b);
        return b ? DR_T : DR_F;
    endfunction

    function automatic logic dr_complete(input dr_t p);
        return |p;
    endfunction

    function automatic logic dr_is_null(input dr_t p);
        return p == DR_NULL;
    endfunction

    // 11 pairs decode as TRUE; the optional checker flags them separately.
    function automatic logic dr_decode(input dr_t p);
        return p[1];
    endfunction

endpackage

// File: rtl/ncl_sync_vec.sv
// Multi-flop synchroniser with asynchronous clear for async NCL signals entering clk.
// Rails are monotonic within a phase, so per-bit synchronisation of a vector is safe.
module ncl_sync_vec #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         init_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [STAGES];

    // shift chain, cleared by reset
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < STAGES; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/ncl_sync_bridge.sv
// Clocked front/back end for a dual-rail NCL ripple-carry adder chain.
// Optional build macro NCL_BRIDGE_CHECK_EN adds a sticky err output for illegal/early rails.
//
// state  | meaning
// I_NULL | injector drives NULL, waits for chain to settle empty then accepts an operand word
// I_DATA | injector holds DATA wavefront until every operand cell reports completion
// C_DATA | collector waits for a complete sum wavefront and a free output register
// C_NULL | collector raises sumCOMP and waits for the chain outputs to return to NULL
module ncl_sync_bridge
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    output logic [2*WIDTH-1:0] a_dr,
    output logic [2*WIDTH-1:0] b_dr,
    output logic [1:0]         cin_dr,
    input  logic [WIDTH-1:0]   opnd_comp,
    input  logic               cin_comp,
    input  logic [2*WIDTH-1:0] sum_dr,
    input  logic [1:0]         cout_dr,
    output logic [WIDTH-1:0]   sum_comp,
    output logic               cout_comp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_cout
`ifdef NCL_BRIDGE_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int CW = WIDTH + 1;
    localparam int RW = 2 * WIDTH + 2;

    logic [CW-1:0] comp_s;
    logic [RW-1:0] rail_s;

    ncl_sync_vec #(.W(CW), .STAGES(SYNC_STAGES)) u_sync_comp (
        .clk    (clk),
        .init_n (init_n),
        .d      ({cin_comp, opnd_comp}),
        .q      (comp_s)
    );

    ncl_sync_vec #(.W(RW), .STAGES(SYNC_STAGES)) u_sync_rail (
        .clk    (clk),
        .init_n (init_n),
        .d      ({cout_dr, sum_dr}),
        .q      (rail_s)
    );

    logic comp_all, comp_none;
    assign comp_all  = &comp_s;
    assign comp_none = ~|comp_s;

    // ---------------- injector ----------------
    inj_state_t           inj_st, inj_nxt;
    logic                 accept, drop_data;
    logic [2*WIDTH-1:0]   a_enc, b_enc;

    // binary operands to dual-rail DATA
    always_comb begin
        a_enc = '0;
        b_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_enc[2*i +: 2] = dr_encode(in_a[i]);
            b_enc[2*i +: 2] = dr_encode(in_b[i]);
        end
    end

    // injector next state
    always_comb begin
        inj_nxt   = inj_st;
        accept    = 1'b0;
        drop_data = 1'b0;
        case (inj_st)
            I_NULL: begin
                accept = in_valid && in_ready;
                if (accept) inj_nxt = I_DATA;
            end
            I_DATA: begin
                if (comp_all) begin
                    drop_data = 1'b1;
                    inj_nxt   = I_NULL;
                end
            end
            default: inj_nxt = I_NULL;
        endcase
    end

    // injector state register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) inj_st <= I_NULL;
        else         inj_st <= inj_nxt;
    end

    // rail drivers and registered ready; ready only once the chain reports empty
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            a_dr     <= '0;
            b_dr     <= '0;
            cin_dr   <= DR_NULL;
            in_ready <= 1'b0;
        end else begin
            if (accept) begin
                a_dr   <= a_enc;
                b_dr   <= b_enc;
                cin_dr <= dr_encode(in_cin);
            end else if (drop_data) begin
                a_dr   <= '0;
                b_dr   <= '0;
                cin_dr <= DR_NULL;
            end
            in_ready <= (inj_nxt == I_NULL) && comp_none;
        end
    end

    // ---------------- collector ----------------
    col_state_t     col_st, col_nxt;
    logic           all_complete, all_null, capture;
    logic [WIDTH:0] word_dec;

    // completeness and decode of the synchronised sum/cout pairs
    always_comb begin
        all_complete = 1'b1;
        all_null     = 1'b1;
        word_dec     = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (!dr_complete(rail_s[2*i +: 2])) all_complete = 1'b0;
            if (!dr_is_null(rail_s[2*i +: 2]))  all_null     = 1'b0;
            word_dec[i] = dr_decode(rail_s[2*i +: 2]);
        end
    end

    // collector next state and completion outputs
    always_comb begin
        col_nxt   = col_st;
        capture   = 1'b0;
        sum_comp  = '0;
        cout_comp = 1'b0;
        case (col_st)
            C_DATA: begin
                if (all_complete && (!out_valid || out_ready)) begin
                    capture = 1'b1;
                    col_nxt = C_NULL;
                end
            end
            C_NULL: begin
                sum_comp  = '1;
                cout_comp = 1'b1;
                if (all_null) col_nxt = C_DATA;
            end
            default: col_nxt = C_DATA;
        endcase
    end

    // collector state register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) col_st <= C_DATA;
        else         col_st <= col_nxt;
    end

    // output holding register; capture may coincide with a pop
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_sum   <= word_dec[WIDTH-1:0];
            out_cout  <= word_dec[WIDTH];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NCL_BRIDGE_CHECK_EN
    logic [RW-1:0] rail_q;
    logic          illegal, early_rise;

    // any 11 pair, or any rail rising while the chain should be draining
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (&rail_s[2*i +: 2]) illegal = 1'b1;
        end
        early_rise = (col_st == C_NULL) && (|(rail_s & ~rail_q));
    end

    // sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rail_q <= '0;
            err    <= 1'b0;
        end else begin
            rail_q <= rail_s;
            if (illegal || early_rise) err <= 1'b1;
        end
    end
`endif

endmodule
